gray_to_bin_tracker: RTL

- Registered Gray-to-binary decoder. It is the inverse end of the team's binary-to-Gray encoder.
- Consumes a Gray-coded monotonic pointer or counter stream, for example a synchronized FIFO pointer.
- Emits the binary value after a fixed 2-cycle pipeline.
- Checks every accepted sample against the previous one. Only a hold (+0) or a single increment (+1, with wrap) is legal. Anything else is flagged and counted.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_to_bin_comb.sv | 20 ++
 rtl/gray_to_bin_tracker.sv | 85 ++++++++
 3 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | gray_pkg : shared Gray-code constants and reference decode  | rev 1.0     |
// +---------------------------------------------------------------------------+
package gray_pkg;

  localparam int GRAY_WIDTH_DEF     = 4;
  localparam int GRAY_ERR_CNT_W_DEF = 8;
  localparam int GRAY_WIDTH_MAX     = 16;

  // Zero-extended inputs decode correctly for any width up to the maximum.
  function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] g);
    logic [GRAY_WIDTH_MAX-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_WIDTH_MAX; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_bin_comb.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | gray_to_bin_comb : combinational Gray-to-binary XOR decoder | rev 1.0     |
// +---------------------------------------------------------------------------+
module gray_to_bin_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at and above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_xor
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/gray_to_bin_tracker.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | gray_to_bin_tracker : 2-stage Gray decoder with +0/+1 step checker        |
// | option macro GRAY_STEP_CHECK_EN enables the checker          | rev 1.0    |
// +---------------------------------------------------------------------------+
module gray_to_bin_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_WIDTH_DEF,
  parameter int ERR_CNT_W = GRAY_ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 gray_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 primed
);

  logic [WIDTH-1:0] g_q;
  logic             v1;
  logic [WIDTH-1:0] dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= gray_valid;
      if (gray_valid) g_q <= gray_in;
    end
  end

  gray_to_bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray (g_q),
    .bin  (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out   <= '0;
      bin_valid <= 1'b0;
    end else begin
      bin_valid <= v1;
      if (v1) bin_out <= dec;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] delta;
  logic             bad_step;

  // Modular difference makes the all-ones to zero wrap a legal +1.
  assign delta    = dec - prev_bin;
  assign bad_step = v1 && primed && (delta > WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bin  <= '0;
      primed    <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
    end else begin
      step_err <= bad_step;
      if (v1) begin
        prev_bin <= dec;
        primed   <= 1'b1;
      end
      if (bad_step && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end
`else
  assign step_err  = 1'b0;
  assign err_count = '0;
  assign primed    = 1'b0;
`endif

endmodule
`default_nettype wire
